// File: rtl/de2i_150_qsys_dpram_ctrl_if.sv
// Avalon-MM bus bundle for both slave ports (s1, s2) of de2i_150_qsys_dpram_ctrl.
interface de2i_150_qsys_dpram_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0]   address,       address2;
    logic                chipselect,    chipselect2;
    logic                read,          read2;
    logic                write,         write2;
    logic [DATA_W/8-1:0] byteenable,    byteenable2;
    logic [DATA_W-1:0]   writedata,     writedata2;
    logic [DATA_W-1:0]   readdata,      readdata2;
    logic                readdatavalid, readdatavalid2;
    logic                waitrequest,   waitrequest2;

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        input  address2, chipselect2, read2, write2, byteenable2, writedata2,
        output readdata, readdatavalid, waitrequest,
        output readdata2, readdatavalid2, waitrequest2
    );

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        output address2, chipselect2, read2, write2, byteenable2, writedata2,
        input  readdata, readdatavalid, waitrequest,
        input  readdata2, readdatavalid2, waitrequest2
    );
endinterface

// File: rtl/de2i_150_qsys_dpram_ctrl.sv
// Dual-port Avalon-MM RAM with post-reset clear, s1-priority write collisions and collision count.
// Optional macro DPRAM_CTRL_OUTREG_EN adds an output register stage (read latency 2).

// Per-port request decode and read-response pipeline.
module de2i_150_qsys_dpram_ctrl_port #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] q,
    output logic              wr_acc,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              in_range;
    logic              rd_acc;
    logic              oor_q;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [DATA_W-1:0] data1;

    assign in_range = {1'b0, addr} < DEPTH_L;
    assign wr_acc   = ready & cs & wr & in_range;
    // read+write in the same cycle is a write only
    assign rd_acc   = ready & cs & rd & ~wr;
    assign vld_pipe = {vld_q, rd_acc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            oor_q <= 1'b0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            oor_q <= ~in_range;
        end
    end

    assign data1 = (vld_pipe[1] && !oor_q) ? q : '0;

    if (STAGES > 1) begin : g_outreg
        logic [DATA_W-1:0] dreg;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) dreg <= '0;
            else          dreg <= data1;
        end
        assign readdata = dreg;
    end else begin : g_direct
        assign readdata = data1;
    end

    assign readdatavalid = vld_pipe[STAGES];
endmodule

module de2i_150_qsys_dpram_ctrl #(
    parameter int                DATA_W      = 64,
    parameter int                DEPTH       = 16384,
    parameter int                ADDR_W      = 14,
    parameter int                CLEAR_EN    = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    de2i_150_qsys_dpram_ctrl_if.slave bus,
    output logic                      init_done,
    output logic [15:0]               collision_cnt
);
    localparam int NUM_PORTS = 2;
    localparam int NB        = DATA_W / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
`ifdef DPRAM_CTRL_OUTREG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_cnt;
    logic             wait_q;
    logic             ready;
    logic             clearing;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] p_addr;
    logic [NUM_PORTS-1:0]             p_cs, p_rd, p_wr, wr_acc, rvalid;
    logic [NUM_PORTS-1:0][NB-1:0]     p_be;
    logic [NUM_PORTS-1:0][DATA_W-1:0] p_wdata, q, rdata;

    assign p_addr  = {bus.address2,    bus.address};
    assign p_cs    = {bus.chipselect2, bus.chipselect};
    assign p_rd    = {bus.read2,       bus.read};
    assign p_wr    = {bus.write2,      bus.write};
    assign p_be    = {bus.byteenable2, bus.byteenable};
    assign p_wdata = {bus.writedata2,  bus.writedata};

    assign ready    = (state == S_READY);
    assign clearing = (state == S_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RESET;
            clr_cnt   <= '0;
            wait_q    <= 1'b1;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    clr_cnt <= '0;
                    if (CLEAR_EN != 0) begin
                        state <= S_CLEAR;
                    end else begin
                        state     <= S_READY;
                        wait_q    <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (clr_cnt == LAST) begin
                        state     <= S_READY;
                        wait_q    <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                S_READY: state <= S_READY;
                default: state <= S_RESET;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        de2i_150_qsys_dpram_ctrl_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .STAGES (STAGES)
        ) u_port (
            .clk           (clk),
            .reset_n       (reset_n),
            .ready         (ready),
            .cs            (p_cs[p]),
            .rd            (p_rd[p]),
            .wr            (p_wr[p]),
            .addr          (p_addr[p]),
            .q             (q[p]),
            .wr_acc        (wr_acc[p]),
            .readdata      (rdata[p]),
            .readdatavalid (rvalid[p])
        );
    end

    // Port A is shared between the clear sequencer and s1.
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              we_a, we_b, same;
    logic [NB-1:0]     be_a, be_b;
    logic [DATA_W-1:0] wd_a;

    assign idx_a = clearing ? clr_cnt : p_addr[0][IDX_W-1:0];
    assign idx_b = p_addr[1][IDX_W-1:0];
    assign we_a  = clearing | wr_acc[0];
    assign be_a  = clearing ? {NB{1'b1}} : p_be[0];
    assign wd_a  = clearing ? CLEAR_VALUE : p_wdata[0];
    assign same  = wr_acc[0] & wr_acc[1] & (p_addr[0] == p_addr[1]);
    // s2 only keeps the lanes s1 leaves untouched on a same-address collision
    assign be_b  = same ? (p_be[1] & ~p_be[0]) : p_be[1];
    assign we_b  = wr_acc[1];

    // No reset on the array; non-blocking reads give old-data read-during-write.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_b && be_b[b]) mem[idx_b][b*8 +: 8] <= p_wdata[1][b*8 +: 8];
            if (we_a && be_a[b]) mem[idx_a][b*8 +: 8] <= wd_a[b*8 +: 8];
        end
        q[0] <= mem[idx_a];
        q[1] <= mem[idx_b];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            collision_cnt <= '0;
        else if (same && collision_cnt != 16'hFFFF)
            collision_cnt <= collision_cnt + 16'd1;
    end

    assign bus.readdata       = rdata[0];
    assign bus.readdata2      = rdata[1];
    assign bus.readdatavalid  = rvalid[0];
    assign bus.readdatavalid2 = rvalid[1];
    assign bus.waitrequest    = wait_q;
    assign bus.waitrequest2   = wait_q;
endmodule

// File: tb/tb_de2i_150_qsys_dpram_ctrl.sv
// Directed bench for de2i_150_qsys_dpram_ctrl: DEPTH=16 and DEPTH=12 instances.
module tb_de2i_150_qsys_dpram_ctrl;
    localparam logic [63:0] CV16 = {8{8'hA5}};
    localparam logic [63:0] CV12 = 64'h0123_4567_89AB_CDEF;
`ifdef DPRAM_CTRL_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init16, init12;
    logic [15:0] cc16, cc12;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    de2i_150_qsys_dpram_ctrl_if #(.DATA_W(64), .ADDR_W(4)) b16 ();
    de2i_150_qsys_dpram_ctrl_if #(.DATA_W(64), .ADDR_W(4)) b12 ();

    de2i_150_qsys_dpram_ctrl #(
        .DATA_W(64), .DEPTH(16), .ADDR_W(4), .CLEAR_EN(1), .CLEAR_VALUE(CV16)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(b16), .init_done(init16), .collision_cnt(cc16)
    );

    de2i_150_qsys_dpram_ctrl #(
        .DATA_W(64), .DEPTH(12), .ADDR_W(4), .CLEAR_EN(1), .CLEAR_VALUE(CV12)
    ) dut12 (
        .clk(clk), .reset_n(reset_n), .bus(b12), .init_done(init12), .collision_cnt(cc12)
    );

    task automatic idle_all();
        b16.chipselect = 0; b16.read = 0; b16.write = 0; b16.address = '0;
        b16.byteenable = '0; b16.writedata = '0;
        b16.chipselect2 = 0; b16.read2 = 0; b16.write2 = 0; b16.address2 = '0;
        b16.byteenable2 = '0; b16.writedata2 = '0;
        b12.chipselect = 0; b12.read = 0; b12.write = 0; b12.address = '0;
        b12.byteenable = '0; b12.writedata = '0;
        b12.chipselect2 = 0; b12.read2 = 0; b12.write2 = 0; b12.address2 = '0;
        b12.byteenable2 = '0; b12.writedata2 = '0;
    endtask

    task automatic rd16(input int p, input logic [3:0] a, output logic [63:0] d, output logic v);
        if (p == 1) begin b16.chipselect = 1; b16.read = 1; b16.address = a; end
        else begin b16.chipselect2 = 1; b16.read2 = 1; b16.address2 = a; end
        @(posedge clk); #1;
        idle_all();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        d = (p == 1) ? b16.readdata : b16.readdata2;
        v = (p == 1) ? b16.readdatavalid : b16.readdatavalid2;
    endtask

    task automatic wr16(input int p, input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        if (p == 1) begin
            b16.chipselect = 1; b16.write = 1; b16.address = a; b16.writedata = d; b16.byteenable = be;
        end else begin
            b16.chipselect2 = 1; b16.write2 = 1; b16.address2 = a; b16.writedata2 = d; b16.byteenable2 = be;
        end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic rd12(input logic [3:0] a, output logic [63:0] d, output logic v);
        b12.chipselect = 1; b12.read = 1; b12.address = a;
        @(posedge clk); #1;
        idle_all();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        d = b12.readdata;
        v = b12.readdatavalid;
    endtask

    task automatic test_reset();
        int n;
        logic [63:0] d;
        logic v;
        idle_all();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (b16.waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_wait: got %b expected 1", b16.waitrequest); end
        n_checks++; if (b16.readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b expected 0", b16.readdatavalid); end
        n_checks++; if (b16.readdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", b16.readdata); end
        n_checks++; if (init16 !== 1'b0) begin n_err++; $display("FAIL rst_init: got %b expected 0", init16); end
        n_checks++; if (cc16 !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0", cc16); end
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1;
        n = 0;
        while (b16.waitrequest === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
        n_checks++; if (n !== 16) begin n_err++; $display("FAIL clear_len: got %0d expected 16", n); end
        n_checks++; if (init16 !== 1'b1) begin n_err++; $display("FAIL init_done: got %b expected 1", init16); end
        n_checks++; if (b16.waitrequest2 !== 1'b0) begin n_err++; $display("FAIL wait2_ready: got %b expected 0", b16.waitrequest2); end
        rd16(1, 4'd15, d, v);
        n_checks++; if (v !== 1'b1) begin n_err++; $display("FAIL clr_rd15_v: got %b expected 1", v); end
        n_checks++; if (d !== CV16) begin n_err++; $display("FAIL clr_rd15_d: got %h expected %h", d, CV16); end
    endtask

    task automatic test_byteenable();
        logic [63:0] d;
        logic v;
        wr16(1, 4'd3, 64'h0011223344556677, 8'h0F);
        rd16(1, 4'd3, d, v);
        n_checks++; if (v !== 1'b1) begin n_err++; $display("FAIL be_v: got %b expected 1", v); end
        n_checks++; if (d !== 64'hA5A5A5A544556677) begin n_err++; $display("FAIL be_d: got %h expected a5a5a5a544556677", d); end
        rd16(2, 4'd3, d, v);
        n_checks++; if (d !== 64'hA5A5A5A544556677 || v !== 1'b1) begin n_err++; $display("FAIL be_s2_d: got %h/%b expected a5a5a5a544556677/1", d, v); end
        wr16(2, 4'd10, 64'h0, 8'h00);
        rd16(1, 4'd10, d, v);
        n_checks++; if (d !== CV16) begin n_err++; $display("FAIL be_zero: got %h expected %h", d, CV16); end
    endtask

    task automatic test_collision();
        logic [63:0] d;
        logic v;
        b16.chipselect = 1; b16.write = 1; b16.address = 4'd5; b16.byteenable = 8'hF0; b16.writedata = '1;
        b16.chipselect2 = 1; b16.write2 = 1; b16.address2 = 4'd5; b16.byteenable2 = 8'hFF; b16.writedata2 = '0;
        @(posedge clk); #1;
        idle_all();
        n_checks++; if (cc16 !== 16'd1) begin n_err++; $display("FAIL coll_cnt: got %0d expected 1", cc16); end
        rd16(1, 4'd5, d, v);
        n_checks++; if (d !== 64'hFFFFFFFF00000000) begin n_err++; $display("FAIL coll_word: got %h expected ffffffff00000000", d); end
        b16.chipselect = 1; b16.write = 1; b16.address = 4'd6; b16.byteenable = 8'hFF; b16.writedata = 64'h66;
        b16.chipselect2 = 1; b16.write2 = 1; b16.address2 = 4'd8; b16.byteenable2 = 8'hFF; b16.writedata2 = 64'h88;
        @(posedge clk); #1;
        idle_all();
        n_checks++; if (cc16 !== 16'd1) begin n_err++; $display("FAIL nocoll_cnt: got %0d expected 1", cc16); end
        rd16(2, 4'd6, d, v);
        n_checks++; if (d !== 64'h66) begin n_err++; $display("FAIL dual_w6: got %h expected 66", d); end
        rd16(1, 4'd8, d, v);
        n_checks++; if (d !== 64'h88) begin n_err++; $display("FAIL dual_w8: got %h expected 88", d); end
    endtask

    task automatic test_read_during_write();
        logic [63:0] d;
        logic v;
        b16.chipselect = 1; b16.read = 1; b16.address = 4'd7;
        b16.chipselect2 = 1; b16.write2 = 1; b16.address2 = 4'd7; b16.byteenable2 = 8'hFF; b16.writedata2 = 64'h1;
        @(posedge clk); #1;
        idle_all();
        repeat (LAT - 1) begin @(posedge clk); #1; end
        n_checks++; if (b16.readdatavalid !== 1'b1) begin n_err++; $display("FAIL rdw_v: got %b expected 1", b16.readdatavalid); end
        n_checks++; if (b16.readdata !== CV16) begin n_err++; $display("FAIL rdw_old: got %h expected %h", b16.readdata, CV16); end
        rd16(1, 4'd7, d, v);
        n_checks++; if (d !== 64'h1) begin n_err++; $display("FAIL rdw_new: got %h expected 1", d); end
    endtask

    task automatic test_read_write_same_port();
        logic [63:0] d;
        logic v;
        b16.chipselect = 1; b16.read = 1; b16.write = 1; b16.address = 4'd9;
        b16.byteenable = 8'hFF; b16.writedata = 64'hCAFE;
        @(posedge clk); #1;
        idle_all();
        n_checks++; if (b16.readdatavalid !== 1'b0) begin n_err++; $display("FAIL rw_norv1: got %b expected 0", b16.readdatavalid); end
        @(posedge clk); #1;
        n_checks++; if (b16.readdatavalid !== 1'b0) begin n_err++; $display("FAIL rw_norv2: got %b expected 0", b16.readdatavalid); end
        rd16(2, 4'd9, d, v);
        n_checks++; if (d !== 64'hCAFE) begin n_err++; $display("FAIL rw_write: got %h expected cafe", d); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  a [3];
        logic [63:0] e [3];
        int k;
        a = '{4'd3, 4'd5, 4'd7};
        e = '{64'hA5A5A5A544556677, 64'hFFFFFFFF00000000, 64'h1};
        for (int i = 0; i < 3 + LAT; i++) begin
            if (i < 3) begin b16.chipselect = 1; b16.read = 1; b16.address = a[i]; end
            else idle_all();
            @(posedge clk); #1;
            k = i - LAT + 1;
            if (k >= 0 && k < 3) begin
                n_checks++; if (b16.readdatavalid !== 1'b1) begin n_err++; $display("FAIL b2b_v%0d: got %b expected 1", k, b16.readdatavalid); end
                n_checks++; if (b16.readdata !== e[k]) begin n_err++; $display("FAIL b2b_d%0d: got %h expected %h", k, b16.readdata, e[k]); end
            end else if (k >= 3) begin
                n_checks++; if (b16.readdatavalid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b expected 0", b16.readdatavalid); end
            end
        end
        idle_all();
    endtask

    task automatic test_out_of_range();
        logic [63:0] d;
        logic v;
        b12.chipselect = 1; b12.write = 1; b12.address = 4'd13; b12.byteenable = 8'hFF; b12.writedata = 64'hDEAD;
        @(posedge clk); #1;
        idle_all();
        rd12(4'd13, d, v);
        n_checks++; if (v !== 1'b1) begin n_err++; $display("FAIL oor_v: got %b expected 1", v); end
        n_checks++; if (d !== 64'h0) begin n_err++; $display("FAIL oor_d: got %h expected 0", d); end
        b12.chipselect = 1; b12.write = 1; b12.address = 4'd13; b12.byteenable = 8'hFF; b12.writedata = 64'h1;
        b12.chipselect2 = 1; b12.write2 = 1; b12.address2 = 4'd13; b12.byteenable2 = 8'hFF; b12.writedata2 = 64'h2;
        @(posedge clk); #1;
        idle_all();
        n_checks++; if (cc12 !== 16'd0) begin n_err++; $display("FAIL oor_coll: got %0d expected 0", cc12); end
        for (int w = 0; w < 12; w++) begin
            rd12(4'(w), d, v);
            n_checks++; if (d !== CV12 || v !== 1'b1) begin n_err++; $display("FAIL oor_keep%0d: got %h/%b expected %h/1", w, d, v, CV12); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        logic [63:0] d;
        logic v;
        b16.chipselect = 1; b16.read = 1; b16.address = 4'd15;
        repeat (LAT + 1) begin @(posedge clk); #1; end
        n_checks++; if (b16.readdatavalid !== 1'b1) begin n_err++; $display("FAIL burst_v: got %b expected 1", b16.readdatavalid); end
        #2 reset_n = 0;
        #1;
        n_checks++; if (b16.readdatavalid !== 1'b0) begin n_err++; $display("FAIL mid_rv: got %b expected 0", b16.readdatavalid); end
        n_checks++; if (b16.readdata !== 64'h0) begin n_err++; $display("FAIL mid_rd: got %h expected 0", b16.readdata); end
        n_checks++; if (cc16 !== 16'h0) begin n_err++; $display("FAIL mid_cnt: got %0d expected 0", cc16); end
        n_checks++; if (b16.waitrequest !== 1'b1 || init16 !== 1'b0) begin n_err++; $display("FAIL mid_wait: got %b/%b expected 1/0", b16.waitrequest, init16); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        idle_all();
        @(posedge clk); #1;
        n = 0;
        while (b16.waitrequest === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
        n_checks++; if (n !== 16) begin n_err++; $display("FAIL reclear_len: got %0d expected 16", n); end
        rd16(1, 4'd3, d, v);
        n_checks++; if (d !== CV16) begin n_err++; $display("FAIL reclear_d: got %h expected %h", d, CV16); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byteenable();
        test_collision();
        test_read_during_write();
        test_read_write_same_port();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
